// File: rtl/interval_integrator_pkg.sv
// Shared constants, note/interval types and FSM encoding for the melody
// interval integrator and its testbench.
package interval_integrator_pkg;

  localparam int DEF_NOTES  = 16;
  localparam int DEF_NOTE_W = 6;
  localparam int DEF_INT_W  = 8;
  localparam int DEF_IDX_W  = 4;

  typedef logic signed [DEF_NOTE_W-1:0] note_t;
  typedef logic signed [DEF_INT_W-1:0]  interval_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/interval_integrator_sat_add.sv
// Combinational saturating signed adder: result = clamp(a + b) to the signed
// OUT_W range, with sat flagging any clamp.
module sat_add_signed #(
  parameter int A_W   = 6,
  parameter int B_W   = 8,
  parameter int OUT_W = 6
) (
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [OUT_W-1:0] result,
  output logic             sat
);

  localparam int SUM_W  = ((A_W > B_W) ? A_W : B_W) + 1;
  // Wide enough for the exact sum and for both clamp limits.
  localparam int CALC_W = (SUM_W > OUT_W) ? SUM_W : OUT_W + 1;

  localparam logic signed [CALC_W-1:0] MAX_V =
    {{(CALC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CALC_W-1:0] MIN_V =
    {{(CALC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [CALC_W-1:0] a_ext;
  logic signed [CALC_W-1:0] b_ext;
  logic signed [CALC_W-1:0] sum;

  assign a_ext = {{(CALC_W-A_W){a[A_W-1]}}, a};
  assign b_ext = {{(CALC_W-B_W){b[B_W-1]}}, b};
  assign sum   = a_ext + b_ext;

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    result = sum[OUT_W-1:0];
    sat    = 1'b0;
    if (sum > MAX_V) begin
      result = MAX_V[OUT_W-1:0];
      sat    = 1'b1;
    end else if (sum < MIN_V) begin
      result = MIN_V[OUT_W-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/interval_integrator.sv
// Rebuilds a melody phrase from a seed note and a stream of signed intervals,
// emitting the saturated running sum as one note per accepted interval.
module interval_integrator
  import interval_integrator_pkg::*;
#(
  parameter int NOTES  = DEF_NOTES,
  parameter int NOTE_W = DEF_NOTE_W,
  parameter int INT_W  = DEF_INT_W,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  input  logic [NOTE_W-1:0] start_note,
  output logic              start_ready,
  input  logic              int_valid,
  input  logic [INT_W-1:0]  int_data,
  output logic              int_ready,
  output logic              note_valid,
  output logic [NOTE_W-1:0] note_data,
  output logic [IDX_W-1:0]  note_idx,
  input  logic              note_ready,
  output logic              phrase_done,
  output logic              sat_flag
);

  localparam logic [IDX_W:0]   NOTES_C  = (IDX_W+1)'(NOTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES - 1);

  state_e              state;
  state_e              state_next;
  logic [NOTE_W-1:0]   acc;
  // One bit wider than the index so it can reach NOTES and stop intake.
  logic [IDX_W:0]      count;
  logic [NOTE_W-1:0]   sum_clamped;
  logic                sum_sat;
  logic                int_hs;
  logic                note_hs;

  assign int_hs  = int_valid && int_ready;
  assign note_hs = note_valid && note_ready;

  sat_add_signed #(
    .A_W   (NOTE_W),
    .B_W   (INT_W),
    .OUT_W (NOTE_W)
  ) u_sat_add (
    .a      (acc),
    .b      (int_data),
    .result (sum_clamped),
    .sat    (sum_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_ready = 1'b0;
    int_ready   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        // A stalled note blocks intake so it is never overwritten.
        int_ready = (count < NOTES_C) && (!note_valid || note_ready);
        if (note_hs && (note_idx == LAST_IDX)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc         <= '0;
      note_data   <= '0;
      note_idx    <= '0;
      note_valid  <= 1'b0;
      count       <= '0;
      sat_flag    <= 1'b0;
      phrase_done <= 1'b0;
    end else begin
      phrase_done <= 1'b0;
      if (state == IDLE) begin
        if (start_valid) begin
          acc        <= start_note;
          note_data  <= start_note;
          note_idx   <= '0;
          note_valid <= 1'b1;
          count      <= (IDX_W+1)'(1);
          sat_flag   <= 1'b0;
        end
      end else if (int_hs) begin
        // The clamped value is carried forward, not the ideal sum.
        acc        <= sum_clamped;
        note_data  <= sum_clamped;
        note_idx   <= count[IDX_W-1:0];
        note_valid <= 1'b1;
        count      <= count + (IDX_W+1)'(1);
        if (sum_sat) sat_flag <= 1'b1;
      end else if (note_hs) begin
        note_valid <= 1'b0;
        if (note_idx == LAST_IDX) phrase_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_interval_integrator.sv
// Scoreboard bench for interval_integrator: a reference model queues the
// expected notes, and a collector pops and compares them on each note handshake.
module tb_interval_integrator;
  import interval_integrator_pkg::*;

  typedef int ivec_t [15];
  typedef struct {
    logic [5:0] data;
    logic [3:0] idx;
    logic       sat;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start_valid;
  logic [5:0] start_note;
  logic       start_ready;
  logic       int_valid;
  logic [7:0] int_data;
  logic       int_ready;
  logic       note_valid;
  logic [5:0] note_data;
  logic [3:0] note_idx;
  logic       note_ready;
  logic       phrase_done;
  logic       sat_flag;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  interval_integrator dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_note  (start_note),
    .start_ready (start_ready),
    .int_valid   (int_valid),
    .int_data    (int_data),
    .int_ready   (int_ready),
    .note_valid  (note_valid),
    .note_data   (note_data),
    .note_idx    (note_idx),
    .note_ready  (note_ready),
    .phrase_done (phrase_done),
    .sat_flag    (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic int clamp_note(input int v);
    if (v > 31)  return 31;
    if (v < -32) return -32;
    return v;
  endfunction

  task automatic expect_phrase(input int seed, input ivec_t iv, input int n);
    int   acc;
    int   raw;
    bit   s;
    exp_t e;
    acc = seed;
    s   = 1'b0;
    e.data = 6'(acc); e.idx = 4'd0; e.sat = 1'b0;
    sb.push_back(e);
    for (int k = 1; k < n; k++) begin
      raw = acc + iv[k-1];
      acc = clamp_note(raw);
      if (acc != raw) s = 1'b1;
      e.data = 6'(acc); e.idx = 4'(k); e.sat = s;
      sb.push_back(e);
    end
  endtask

  task automatic drive_start(input int seed, output bit pd_at_hs);
    bit ok;
    ok = 1'b0;
    pd_at_hs = 1'b0;
    start_note  = 6'(seed);
    start_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (start_ready) begin
        ok = 1'b1;
        pd_at_hs = phrase_done;
      end
      @(posedge clk); #1;
    end
    start_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL start_timeout start_ready=%0b required=1", start_ready);
    end
  endtask

  task automatic drive_int(input int val);
    bit ok;
    ok = 1'b0;
    int_data  = 8'(val);
    int_valid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (int_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    int_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL int_timeout int_ready=%0b required=1", int_ready);
    end
  endtask

  task automatic drive_phrase(input int seed, input ivec_t iv, input bit glitch,
                              output bit pd_at_start);
    drive_start(seed, pd_at_start);
    if (glitch) begin
      start_note  = 6'(-9);
      start_valid = 1'b1;
    end
    for (int k = 0; k < 15; k++) drive_int(iv[k]);
    start_valid = 1'b0;
  endtask

  task automatic collect_notes(input int n, output int pd_seen,
                               output int first_cyc, output int last_cyc);
    int   got;
    int   waited;
    exp_t e;
    got = 0; waited = 0; pd_seen = 0; first_cyc = -1; last_cyc = -1;
    while (got < n && waited < 3000) begin
      @(negedge clk);
      waited++;
      if (phrase_done) pd_seen++;
      if (note_valid && note_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL note_unexpected data=%0d idx=%0d", $signed(note_data), note_idx);
        end else begin
          e = sb.pop_front();
          if (note_data !== e.data || note_idx !== e.idx || sat_flag !== e.sat) begin
            failures++;
            $display("FAIL note got data=%0d idx=%0d sat=%0b expected data=%0d idx=%0d sat=%0b",
                     $signed(note_data), note_idx, sat_flag, $signed(e.data), e.idx, e.sat);
          end
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
    end
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL note_timeout got=%0d expected=%0d", got, n);
    end
  endtask

  task automatic ready_ctl(input int stall_idx, input int stall_len);
    logic [5:0] d;
    logic [3:0] ix;
    bit         done;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      if (note_valid && note_idx == 4'(stall_idx)) begin
        d  = note_data;
        ix = note_idx;
        note_ready = 1'b0;
        repeat (stall_len) begin
          @(negedge clk);
          checks++;
          if (int_ready !== 1'b0 || note_valid !== 1'b1 || note_data !== d ||
              note_idx !== ix || start_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold int_ready=%0b valid=%0b data=%0d idx=%0d expected int_ready=0 valid=1 data=%0d idx=%0d",
                     int_ready, note_valid, $signed(note_data), note_idx, $signed(d), ix);
          end
          @(posedge clk); #1;
        end
        note_ready = 1'b1;
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL stall_never_reached idx=%0d", stall_idx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({note_valid, note_data, note_idx, phrase_done, sat_flag, start_ready, int_ready}
        !== {1'b0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_values valid=%0b data=%0d idx=%0d done=%0b sat=%0b sr=%0b ir=%0b required 0 0 0 0 0 1 0",
               note_valid, note_data, note_idx, phrase_done, sat_flag, start_ready, int_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    ivec_t iv;
    int pd, f, l;
    bit x;
    foreach (iv[k]) iv[k] = 1;
    expect_phrase(0, iv, 16);
    fork
      collect_notes(16, pd, f, l);
      drive_phrase(0, iv, 1'b0, x);
    join
    checks++;
    if (pd !== 0 || (l - f) !== 15) begin
      failures++;
      $display("FAIL ramp_timing done_early=%0d span=%0d required 0 15", pd, l - f);
    end
    @(negedge clk);
    checks++;
    if (phrase_done !== 1'b1 || note_valid !== 1'b0 || start_ready !== 1'b1 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL ramp_done done=%0b valid=%0b sr=%0b sat=%0b required 1 0 1 0",
               phrase_done, note_valid, start_ready, sat_flag);
    end
    @(negedge clk);
    checks++;
    if (phrase_done !== 1'b0) begin
      failures++;
      $display("FAIL ramp_done_pulse done=%0b required 0", phrase_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    ivec_t iv;
    int pd, f, l;
    bit x;
    iv = '{5, -100, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expect_phrase(30, iv, 16);
    fork
      collect_notes(16, pd, f, l);
      drive_phrase(30, iv, 1'b0, x);
    join
    @(negedge clk);
    checks++;
    if (phrase_done !== 1'b1 || sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_done done=%0b sat=%0b required 1 1", phrase_done, sat_flag);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sat_flag !== 1'b1) begin
      failures++;
      $display("FAIL sat_sticky sat=%0b required 1", sat_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    ivec_t iv;
    int pd, f, l;
    bit x;
    foreach (iv[k]) iv[k] = -3;
    expect_phrase(20, iv, 16);
    fork
      collect_notes(16, pd, f, l);
      drive_phrase(20, iv, 1'b0, x);
      ready_ctl(4, 3);
    join
    checks++;
    if ((l - f) !== 18) begin
      failures++;
      $display("FAIL bp_span span=%0d required 18", l - f);
    end
    @(negedge clk);
    checks++;
    if (phrase_done !== 1'b1 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL bp_done done=%0b sat=%0b required 1 0", phrase_done, sat_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    ivec_t iv;
    int pd, f, l;
    bit x;
    bit bad;
    iv = '{10, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    expect_phrase(31, iv, 8);
    fork
      collect_notes(8, pd, f, l);
      begin
        drive_start(31, x);
        for (int k = 0; k < 7; k++) drive_int(iv[k]);
      end
    join
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({note_valid, note_data, note_idx, phrase_done, sat_flag, start_ready, int_ready}
        !== {1'b0, 6'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL midreset_values valid=%0b data=%0d idx=%0d done=%0b sat=%0b sr=%0b ir=%0b required 0 0 0 0 0 1 0",
               note_valid, note_data, note_idx, phrase_done, sat_flag, start_ready, int_ready);
    end
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (phrase_done !== 1'b0 || note_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midreset_quiet spurious done/valid seen=1 required 0");
    end
    @(posedge clk); #1;
    foreach (iv[k]) iv[k] = 2;
    expect_phrase(-5, iv, 16);
    fork
      collect_notes(16, pd, f, l);
      drive_phrase(-5, iv, 1'b0, x);
    join
    @(negedge clk);
    checks++;
    if (phrase_done !== 1'b1) begin
      failures++;
      $display("FAIL midreset_restart_done done=%0b required 1", phrase_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_protocol();
    ivec_t iv;
    int pd, f, l;
    bit x;
    bit bad;
    bad = 1'b0;
    int_data  = 8'd7;
    int_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (int_ready !== 1'b0 || note_valid !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    int_valid = 1'b0;
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_int_ignored int_ready/valid seen=1 required 0");
    end
    foreach (iv[k]) iv[k] = (k % 2 == 0) ? 4 : -3;
    expect_phrase(-20, iv, 16);
    fork
      collect_notes(16, pd, f, l);
      drive_phrase(-20, iv, 1'b1, x);
    join
    @(negedge clk);
    checks++;
    if (phrase_done !== 1'b1) begin
      failures++;
      $display("FAIL glitch_done done=%0b required 1", phrase_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    ivec_t iva;
    ivec_t ivb;
    int pd, f, l;
    bit x;
    bit pd_at;
    foreach (iva[k]) iva[k] = 1;
    foreach (ivb[k]) ivb[k] = 3;
    expect_phrase(10, iva, 16);
    expect_phrase(-30, ivb, 16);
    fork
      collect_notes(32, pd, f, l);
      begin
        drive_phrase(10, iva, 1'b0, x);
        drive_phrase(-30, ivb, 1'b0, pd_at);
      end
    join
    checks++;
    if (pd_at !== 1'b1 || pd !== 1 || (l - f) !== 32) begin
      failures++;
      $display("FAIL b2b_timing done_at_start=%0b dones=%0d span=%0d required 1 1 32",
               pd_at, pd, l - f);
    end
    @(negedge clk);
    checks++;
    if (phrase_done !== 1'b1 || sb.size() !== 0) begin
      failures++;
      $display("FAIL b2b_done done=%0b leftover=%0d required 1 0", phrase_done, sb.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset       = 1'b1;
    start_valid = 1'b0;
    start_note  = '0;
    int_valid   = 1'b0;
    int_data    = '0;
    note_ready  = 1'b1;
    test_reset();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_protocol();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interval_integrator.md
Name: interval_integrator

Overview:
- Reconstructs a 16-note melody phrase from a seed note followed by 15 signed pitch intervals.
- Each output note is the running sum of the seed and the intervals received so far.
- Sits on the generation/playback side of the emotion analyzer and performs the inverse of interval feature extraction.
- Intervals arrive serially over valid/ready; notes leave serially over valid/ready, saturated to the note range.

Parameters:
- NOTES, 16, notes per phrase (seed + NOTES-1 intervals)
- NOTE_W, 6, signed note width
- INT_W, 8, signed interval width
- IDX_W, 4, note index width, equal to clog2(NOTES)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start_valid  in  1  seed note offered
- start_note  in  NOTE_W  signed seed note
- start_ready  out  1  high only in IDLE
- int_valid  in  1  interval offered
- int_data  in  INT_W  signed interval
- int_ready  out  1  interval accepted when int_valid && int_ready
- note_valid  out  1  note_data valid
- note_data  out  NOTE_W  signed reconstructed note
- note_idx  out  IDX_W  position of note_data in the phrase (0..NOTES-1)
- note_ready  in  1  downstream accepts note
- phrase_done  out  1  one-cycle pulse after the final note is accepted
- sat_flag  out  1  sticky: a clamp occurred in the current phrase

Behaviour:
- Clocking and reset:
  - One clock; reset is synchronous and active-high.
  - Reset returns the FSM to IDLE and clears all registers.
  - Reset values: note_valid=0, note_data=0, note_idx=0, phrase_done=0, sat_flag=0, accumulator=0, count=0.
  - Reset values of the combinational outputs: start_ready=1, int_ready=0.
  - Reset mid-phrase abandons the phrase immediately; no phrase_done is generated.
- FSM states: IDLE, RUN.
- IDLE:
  - start_ready=1, int_ready=0; int_valid is ignored.
  - On start_valid, in the next cycle:
    - acc=start_note, note_data=start_note, note_idx=0
    - note_valid=1, count=1, sat_flag=0
    - state=RUN
- RUN:
  - start_ready=0; start_valid is ignored.
  - int_ready = (count < NOTES) && (!note_valid || note_ready).
  - On an int handshake:
    - sum = sign-extended acc + sign-extended int_data, computed at max(NOTE_W,INT_W)+1 bits (9 bits by default, no overflow possible).
    - clamp = sum limited to [-2^(NOTE_W-1), 2^(NOTE_W-1)-1], i.e. [-32, 31] by default.
    - Next cycle: acc=clamp, note_data=clamp, note_idx=count, note_valid=1, count=count+1.
    - sat_flag is set if clamp != sum.
  - A note handshake (note_valid && note_ready) with no int handshake in the same cycle clears note_valid.
  - A note handshake and an int handshake in the same cycle: the new note replaces the old one and note_valid stays 1. Throughput is 1 note/cycle.
  - Latency: int handshake to note_valid of the resulting note is 1 cycle.
  - While note_valid && !note_ready: note_data and note_idx hold stable and int_ready=0.
  - Phrase end: on the note handshake with note_idx==NOTES-1:
    - next cycle: phrase_done=1 for one cycle, note_valid=0, state=IDLE
    - sat_flag holds until the next start.
  - Back-to-back phrases: start_ready rises in the same cycle as phrase_done, so the next start handshake can occur in that cycle.
- Accumulation rule: the accumulator tracks the clamped value, not the ideal sum.

Decomposition:
- Shared package: NOTE_W, INT_W, NOTES constants; note_t and interval_t signed types; the FSM state encoding (IDLE, RUN).
- One natural sub-module: sat_add_signed, a combinational saturating signed adder.
  - Parameters: A_W, B_W, OUT_W.
  - Outputs: result and a sat bit.
  - Reusable elsewhere in the analyzer datapath.

Test Plan:
- Ramp: start_note=0, 15 intervals of +1, note_ready=1 held → notes 0..15 with note_idx 0..15 on consecutive cycles; phrase_done pulses exactly once, one cycle after note 15; sat_flag=0.
- Saturation: start 30, intervals +5, -100, +10, then +0 x12 → notes 30, 31, -32, -22, then -22 x12; sat_flag=1 from the cycle note 31 appears until the next start.
- Backpressure: descending phrase with note_ready=0 for 3 cycles at note_idx=4 → int_ready=0 throughout, note_data/note_idx stable, no interval lost; the sequence resumes correctly.
- Reset mid-phrase: reset asserted after note_idx=7 → next cycle all outputs at reset values, no phrase_done; a new start (seed -5) begins at note_idx=0 with sat_flag=0.
- Protocol guards: start_valid pulsed during RUN is ignored; int_valid=1 in IDLE → int_ready=0 and nothing is consumed. Start issued in the phrase_done cycle → new seed appears the next cycle.
